// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and opcode constants for the fetch stage
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      DRAIN  = 2'd2,
      HALTED = 2'd3
   } fetch_state_t;

   localparam logic [5:0]  OP_CLOSE  = 6'b110001;
   localparam logic [5:0]  OP_START  = 6'b110010;
   localparam int          OP_MSB    = 31;
   localparam int          OP_LSB    = 26;
   localparam logic [31:0] NOP_INSTR = '0;

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// rtl/fetch_unit_if_id_reg.sv - IF/ID pipeline register; flush beats hold beats load
import fetch_pkg::*;

module if_id_reg #(
   parameter int ADDR_W  = 32,
   parameter int INSTR_W = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_i,
   input  logic               flush_i,
   input  logic               hold_i,
   input  logic [INSTR_W-1:0] instr_i,
   input  logic [ADDR_W-1:0]  pc_plus4_i,
   output logic [INSTR_W-1:0] instr_o,
   output logic [ADDR_W-1:0]  pc_plus4_o,
   output logic               valid_o
);

   logic [INSTR_W-1:0] instr_q;
   logic [ADDR_W-1:0]  pc_plus4_q;
   logic               valid_q;

   always_ff @(posedge clk) begin
      if (!rst_n || flush_i) begin
         instr_q    <= INSTR_W'(NOP_INSTR);
         pc_plus4_q <= '0;
         valid_q    <= 1'b0;
      end else if (!hold_i && load_i) begin
         instr_q    <= instr_i;
         pc_plus4_q <= pc_plus4_i;
         valid_q    <= 1'b1;
      end
   end

   assign instr_o    = instr_q;
   assign pc_plus4_o = pc_plus4_q;
   assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: PC, run-control FSM, IF/ID register
import fetch_pkg::*;

module fetch_unit #(
   parameter int                ADDR_W       = 32,
   parameter int                INSTR_W      = 32,
   parameter logic [ADDR_W-1:0] RESET_PC     = '0,
   parameter int                DRAIN_CYCLES = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start_i,
   input  logic               stall_i,
   input  logic               redirect_i,
   input  logic [ADDR_W-1:0]  redirect_pc_i,
   output logic [ADDR_W-1:0]  imem_addr_o,
   input  logic [INSTR_W-1:0] imem_data_i,
   output logic [INSTR_W-1:0] instr_d_o,
   output logic [ADDR_W-1:0]  pc_plus4_d_o,
   output logic               valid_d_o,
   output logic               running_o,
   output logic               done_o
);

   localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              running_q, done_q;
   logic              load, flush, hold;
   logic              is_close;
   logic [ADDR_W-1:0] pc_plus4;

   assign pc_plus4 = pc_q + ADDR_W'(4);
   assign is_close = (imem_data_i[OP_MSB:OP_LSB] == OP_CLOSE);

   // IF/ID defaults to bubble; only a live RUN/DRAIN cycle loads or holds it
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      flush   = 1'b1;
      hold    = 1'b0;
      load    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) state_d = RUN;
         end
         RUN: begin
            if (redirect_i) begin
               pc_d = redirect_pc_i;
            end else if (stall_i) begin
               flush = 1'b0;
               hold  = 1'b1;
            end else begin
               flush = 1'b0;
               load  = 1'b1;
               if (is_close) begin
                  state_d = DRAIN;
                  cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
               end else begin
                  pc_d = pc_plus4;
               end
            end
         end
         DRAIN: begin
            // an older branch resolving now means the close was wrong-path
            if (redirect_i) begin
               pc_d    = redirect_pc_i;
               state_d = RUN;
            end else if (stall_i) begin
               flush = 1'b0;
               hold  = 1'b1;
            end else if (cnt_q == '0) begin
               state_d = HALTED;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         HALTED: begin
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pc_q      <= RESET_PC;
         cnt_q     <= '0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         cnt_q     <= cnt_d;
         running_q <= (state_d == RUN) || (state_d == DRAIN);
         done_q    <= (state_d == HALTED);
      end
   end

   if_id_reg #(
      .ADDR_W  (ADDR_W),
      .INSTR_W (INSTR_W)
   ) u_if_id (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (load),
      .flush_i    (flush),
      .hold_i     (hold),
      .instr_i    (imem_data_i),
      .pc_plus4_i (pc_plus4),
      .instr_o    (instr_d_o),
      .pc_plus4_o (pc_plus4_d_o),
      .valid_o    (valid_d_o)
   );

   assign imem_addr_o = pc_q;
   assign running_o   = running_q;
   assign done_o      = done_q;

endmodule
